// File: rtl/rv_commit_trace.sv
// Commit trace buffer: captures retired instructions into a circular buffer around a
// PC trigger, then drains the frozen window oldest-first over a valid/ready port.
module rv_commit_trace #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] inst,
  input  logic [4:0]      rd,
  input  logic            rfwenable,
  input  logic [XLEN-1:0] res,
  input  logic            arm,
  input  logic [XLEN-1:0] trig_pc,
  input  logic [CW-1:0]   post_count,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [XLEN-1:0] rd_pc,
  output logic [XLEN-1:0] rd_inst,
  output logic [4:0]      rd_rd,
  output logic            rd_wb,
  output logic [XLEN-1:0] rd_res,
  output logic [1:0]      state,
  output logic [CW-1:0]   count,
  output logic            overflow
);

  localparam int AW = $clog2(DEPTH);

  // state | meaning
  // IDLE  | not capturing, commits ignored
  // ARMED | capturing into ring, waiting for trig_pc
  // POST  | capturing the post-trigger window
  // DONE  | frozen, draining via rd_*
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [XLEN-1:0] trig_pc_q, trig_pc_d;
  logic [CW-1:0]   post_q, post_d;
  logic [CW-1:0]   remaining_q, remaining_d;
  logic            we;

  logic [XLEN-1:0] mem_pc_q   [DEPTH];
  logic [XLEN-1:0] mem_inst_q [DEPTH];
  logic [4:0]      mem_rd_q   [DEPTH];
  logic            mem_wb_q   [DEPTH];
  logic [XLEN-1:0] mem_res_q  [DEPTH];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    trig_pc_d   = trig_pc_q;
    post_d      = post_q;
    remaining_d = remaining_q;
    we          = 1'b0;

    if (arm) begin
      state_d     = ARMED;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      remaining_d = '0;
      trig_pc_d   = trig_pc;
      post_d      = (post_count > CW'(DEPTH - 1)) ? CW'(DEPTH - 1) : post_count;
    end else begin
      case (state_q)
        ARMED, POST: begin
          if (commit_valid) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            // Full ring: the write lands on the oldest entry, so the read side slips forward.
            if (count_q == CW'(DEPTH)) begin
              rd_ptr_d = rd_ptr_q + AW'(1);
              if (state_q == ARMED) overflow_d = 1'b1;
            end else begin
              count_d = count_q + CW'(1);
            end
            if (state_q == ARMED) begin
              if (pc == trig_pc_q) begin
                if (post_q == '0) begin
                  state_d = DONE;
                end else begin
                  state_d     = POST;
                  remaining_d = post_q;
                end
              end
            end else begin
              remaining_d = remaining_q - CW'(1);
              if (remaining_q == CW'(1)) state_d = DONE;
            end
          end
        end
        DONE: begin
          if ((count_q != '0) && rd_ready) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      trig_pc_q   <= '0;
      post_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      trig_pc_q   <= trig_pc_d;
      post_q      <= post_d;
      remaining_q <= remaining_d;
    end
  end

  // Trace RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem_pc_q[wr_ptr_q]   <= pc;
      mem_inst_q[wr_ptr_q] <= inst;
      mem_rd_q[wr_ptr_q]   <= rd & {5{rfwenable}};
      mem_wb_q[wr_ptr_q]   <= rfwenable;
      mem_res_q[wr_ptr_q]  <= res;
    end
  end

  assign rd_valid = (state_q == DONE) && (count_q != '0);
  assign rd_pc    = mem_pc_q[rd_ptr_q];
  assign rd_inst  = mem_inst_q[rd_ptr_q];
  assign rd_rd    = mem_rd_q[rd_ptr_q];
  assign rd_wb    = mem_wb_q[rd_ptr_q];
  assign rd_res   = mem_res_q[rd_ptr_q];
  assign state    = state_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_rv_commit_trace.sv
// Scoreboard bench for rv_commit_trace (DEPTH=8): queue-based trace model, monitor on the drain port.
module tb_rv_commit_trace;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            commit_valid = 1'b0;
  logic [XLEN-1:0] pc = '0, inst = '0, res = '0;
  logic [4:0]      rd = '0;
  logic            rfwenable = 1'b0;
  logic            arm = 1'b0;
  logic [XLEN-1:0] trig_pc = '0;
  logic [CW-1:0]   post_count = '0;
  logic            rd_valid, rd_ready = 1'b0;
  logic [XLEN-1:0] rd_pc, rd_inst, rd_res;
  logic [4:0]      rd_rd;
  logic            rd_wb;
  logic [1:0]      state;
  logic [CW-1:0]   count;
  logic            overflow;

  rv_commit_trace #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .pc(pc), .inst(inst), .rd(rd),
    .rfwenable(rfwenable), .res(res), .arm(arm), .trig_pc(trig_pc), .post_count(post_count),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_rd(rd_rd),
    .rd_wb(rd_wb), .rd_res(rd_res), .state(state), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        wb;
    logic [31:0] res;
  } ent_t;

  ent_t model_q[$];   // capture ring while ARMED/POST
  ent_t exp_q[$];     // frozen window, expected drain order
  int   mmode = 0;    // 0 idle, 1 armed, 2 post, 3 done
  int   mrem = 0, mpost = 0;
  logic [31:0] mtrig = '0;
  logic mover = 1'b0;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int mcount();
    return (mmode == 3) ? exp_q.size() : model_q.size();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_state"}, 64'(state), 64'(mmode));
    chk({tag, "_count"}, 64'(count), 64'(mcount()));
    chk({tag, "_overflow"}, 64'(overflow), 64'(mover));
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'((mmode == 3) && (mcount() != 0)));
  endtask

  task automatic model_commit(input ent_t e);
    if (mmode == 1 || mmode == 2) begin
      model_q.push_back(e);
      if (model_q.size() > DEPTH) begin
        void'(model_q.pop_front());
        if (mmode == 1) mover = 1'b1;
      end
      if (mmode == 1) begin
        if (e.pc == mtrig) begin
          if (mpost == 0) mmode = 3;
          else begin mmode = 2; mrem = mpost; end
        end
      end else begin
        mrem--;
        if (mrem == 0) mmode = 3;
      end
      if (mmode == 3) begin
        exp_q = model_q;
        model_q.delete();
      end
    end
  endtask

  task automatic drive_commit(input logic [31:0] p, input logic w, input logic [4:0] r);
    commit_valid = 1'b1;
    pc = p; inst = $urandom; res = $urandom; rd = r; rfwenable = w;
  endtask

  task automatic do_commit(input logic [31:0] p, input logic w, input logic [4:0] r);
    ent_t e;
    drive_commit(p, w, r);
    e.pc = p; e.inst = inst; e.rd = r & {5{w}}; e.wb = w; e.res = res;
    model_commit(e);
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [31:0] t, input int post, input bit with_commit);
    arm = 1'b1; trig_pc = t; post_count = CW'(post);
    if (with_commit) drive_commit(t, 1'b1, 5'd1);
    mmode = 1; model_q.delete(); exp_q.delete(); mover = 1'b0;
    mtrig = t; mpost = (post > DEPTH - 1) ? DEPTH - 1 : post;
    tick();
    arm = 1'b0; commit_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    mmode = 0; model_q.delete(); exp_q.delete(); mover = 1'b0;
  endtask

  task automatic drain(input bit rand_ready);
    int k = 0;
    while (mcount() != 0 && k < 200) begin
      rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      check_status("drain");
      k++;
    end
    rd_ready = 1'b0;
    tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_rd_valid", 64'(rd_valid), 64'd0);
  endtask

  // Monitor: every accepted beat must match the head of the expected window.
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 64'(rd_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("mon_pc", 64'(rd_pc), 64'(e.pc));
        chk("mon_inst", 64'(rd_inst), 64'(e.inst));
        chk("mon_rd", 64'(rd_rd), 64'(e.rd));
        chk("mon_wb", 64'(rd_wb), 64'(e.wb));
        chk("mon_res", 64'(rd_res), 64'(e.res));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_status("reset0");

    // T1: reset mid-capture
    do_arm(32'h0, 3, 1'b0);
    for (int i = 0; i < 5; i++) do_commit(32'h1000 + 32'(i * 4), 1'b1, 5'd2);
    do_reset();
    check_status("t1");
    chk("t1_state", 64'(state), 64'd0);
    chk("t1_count", 64'(count), 64'd0);

    // T2: trigger window
    do_arm(32'h0C, 2, 1'b0);
    for (int i = 0; i < 5; i++) do_commit(32'(i * 4), 1'b1, 5'(i + 1));
    chk("t2_post", 64'(state), 64'd2);
    do_commit(32'h14, 1'b1, 5'd7);
    chk("t2_done", 64'(state), 64'd3);
    chk("t2_count", 64'(count), 64'd6);
    do_commit(32'h18, 1'b1, 5'd8);
    chk("t2_count_after", 64'(count), 64'd6);
    chk("t2_first", 64'(rd_pc), 64'h0);
    drain(1'b0);

    // T3: wrap with overflow
    do_arm(32'h2C, 0, 1'b0);
    for (int i = 0; i < 12; i++) do_commit(32'(i * 4), 1'b1, 5'd3);
    chk("t3_state", 64'(state), 64'd3);
    chk("t3_count", 64'(count), 64'd8);
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_first", 64'(rd_pc), 64'h10);
    drain(1'b0);

    // T4: backpressure
    do_arm(32'h100, 2, 1'b0);
    do_commit(32'h100, 1'b1, 5'd4);
    do_commit(32'h104, 1'b1, 5'd5);
    do_commit(32'h108, 1'b1, 5'd6);
    chk("t4_count", 64'(count), 64'd3);
    for (int i = 0; i < 3; i++) begin
      rd_ready = 1'b0;
      tick();
      chk("t4_hold_valid", 64'(rd_valid), 64'd1);
      chk("t4_hold_pc", 64'(rd_pc), 64'h100);
      chk("t4_hold_count", 64'(count), 64'd3);
    end
    rd_ready = 1'b1;
    tick(); tick(); tick();
    rd_ready = 1'b0;
    chk("t4_count_end", 64'(count), 64'd0);
    chk("t4_valid_end", 64'(rd_valid), 64'd0);
    chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);

    // T5: re-arm while in POST, commit in arm cycle not captured
    do_arm(32'h40, 5, 1'b0);
    do_commit(32'h40, 1'b1, 5'd1);
    do_commit(32'h44, 1'b1, 5'd1);
    chk("t5_post", 64'(state), 64'd2);
    do_arm(32'h40, 2, 1'b1);
    chk("t5_state", 64'(state), 64'd1);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_overflow", 64'(overflow), 64'd0);

    // T6: post_count clamp and masked rd
    do_arm(32'h200, 15, 1'b0);
    do_commit(32'h1FC, 1'b1, 5'd9);
    do_commit(32'h200, 1'b1, 5'd9);
    for (int i = 0; i < 7; i++) begin
      chk("t6_not_done", 64'(state), 64'd2);
      if (i == 2) do_commit(32'h204 + 32'(i * 4), 1'b0, 5'd5);
      else        do_commit(32'h204 + 32'(i * 4), 1'b1, 5'd6);
    end
    chk("t6_done", 64'(state), 64'd3);
    chk("t6_count", 64'(count), 64'd8);
    chk("t6_overflow", 64'(overflow), 64'd0);
    chk("t6_first", 64'(rd_pc), 64'h200);
    rd_ready = 1'b1;
    tick(); tick(); tick();
    rd_ready = 1'b0;
    chk("t6_nowb_pc", 64'(rd_pc), 64'h20C);
    chk("t6_nowb_rd", 64'(rd_rd), 64'd0);
    chk("t6_nowb_wb", 64'(rd_wb), 64'd0);
    drain(1'b1);

    // Randomised rounds against the model
    for (int r = 0; r < 12; r++) begin
      do_arm(32'($urandom_range(0, 15) * 4), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      check_status("rnd_arm");
      for (int c = 0; c < 40 && mmode != 3; c++) begin
        if ($urandom_range(0, 3) == 0) tick();
        else begin
          p = 32'($urandom_range(0, 15) * 4);
          do_commit(p, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end
        check_status("rnd_cap");
      end
      if (mmode == 3) drain(1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
